sysbus_mem_responder: RTL
=========================

# sysbus_mem_responder

Memory-side responder for the system bus. Accepts 64-byte-line read and write requests from an initiator (fetch unit, cache, test driver) on the request channel and services them from an internal word-addressed array. Read data is returned as an 8-beat burst on the response channel, paced by the initiator's per-beat acknowledge. It is the simulation/FPGA stand-in for DRAM behind the bus.

## Interface
- BUS_DATA_WIDTH, 64, data/address width of req/resp channels
- BUS_TAG_WIDTH, 13, tag width; tag[12] = op (`SYSBUS_READ`/`SYSBUS_WRITE`), tag[11:8] = device, tag[7:0] = transaction id
- MEM_WORDS, 4096, array depth in 64-bit words (power of two)
- READ_LATENCY, 4, idle cycles between request ack and first read beat (≥1)

- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- bus_reqcyc  in  1  initiator request/write-beat valid
- bus_req  in  BUS_DATA_WIDTH  request address, or write data during write beats
- bus_reqtag  in  BUS_TAG_WIDTH  request tag, sampled with the address
- bus_reqack  out  1  request/write-beat accepted
- bus_respcyc  out  1  read beat valid
- bus_resp  out  BUS_DATA_WIDTH  read beat data
- bus_resptag  out  BUS_TAG_WIDTH  echo of the accepted request tag
- bus_respack  in  1  initiator has consumed the current beat

## Operation
- States: IDLE, WAIT, RDATA, WDATA.
- IDLE: request accepted when bus_reqcyc=1 and tag[11:8]=`SYSBUS_MEMORY`. Latch line index = bus_req[63:6], tag; beat counter = 0; assert bus_reqack next cycle for exactly one cycle. Read → WAIT; write → WDATA.
- Non-MEMORY device field: never acked; block stays IDLE.
- Word address = {line index, beat[2:0]} modulo MEM_WORDS (wraps silently; bus_req[5:0] ignored).
- WAIT: count READ_LATENCY cycles, then → RDATA.
- RDATA: bus_respcyc=1, bus_resp = mem[word], bus_resptag = latched tag. Beat advances only on a cycle with bus_respcyc=1 and bus_respack=1; the next beat is presented the following cycle. bus_resp is held stable while unacked. Ack of beat 7 → bus_respcyc=0 next cycle, → IDLE.
- WDATA: each cycle with bus_reqcyc=1 is one write beat: mem[word] ← bus_req, bus_reqack=1 next cycle, beat+1. After beat 7 → IDLE. Cycles with bus_reqcyc=0 are stalls.
- While not IDLE, new requests are not acked; initiator holds bus_reqcyc.
- Beat counter is 3 bits; wraps only at burst end.

## Timing
- Reset (asynchronous, reset=0): state IDLE, bus_reqack=0, bus_respcyc=0, bus_resp=0, bus_resptag=0, counters 0. Array contents not cleared. Reset mid-burst aborts immediately; no further beats.
- Request ack latency: 1 cycle after accepting edge.
- First read beat: bus_respcyc rises READ_LATENCY+1 cycles after the accepting edge.
- Minimum read burst: 8 beats, 1 beat/cycle when bus_respack is held high.
- bus_respack while bus_respcyc=0: ignored.
- Write beat in the same cycle as the ack of the address: not allowed; first write beat sampled no earlier than the cycle after address acceptance.
- All outputs registered.

## Configuration
- `SYSBUS_MEMRESP_WRITE_EN` defined: writes update the array as above.
- Undefined: write requests are still acked and their 8 data beats consumed and acked identically, but the array is not modified (read-only memory).

## Test plan
- Preload mem[8..15] = 64'h1000+i; read addr 64'h40, tag = READ|MEMORY|8'h2A, respack held 1 → reqack one cycle, 8 beats 64'h1000..64'h1007 on consecutive cycles, resptag = tag, respcyc first rises 5 cycles after accept (latency 4).
- Same read, respack toggled 1,0,0,1… → beat data held across unacked cycles, exactly 8 beats, order preserved.
- Write addr 64'h80 with data 64'hA0..A7 (with stall cycles), then read 64'h80 → returns A0..A7; with macro undefined → returns preloaded values, writes still acked 8 times.
- Request with device ≠ MEMORY → bus_reqack stays 0 for 20 cycles, state IDLE.
- Address 64'h40 + MEM_WORDS*8 → same data as 64'h40 (wrap).
- reset=0 during beat 3 of a read → respcyc/reqack drop immediately; after release, new read completes normally.

Source files
------------

// File: rtl/sysbus_mem_responder.sv
// sysbus_mem_responder
//
// Memory-side responder for the system bus. It stands in for DRAM behind the
// bus. It accepts 64-byte-line read and write requests and services them from
// an internal array of 64-bit words. Read data comes back as an 8-beat burst,
// and the initiator paces the burst with a per-beat acknowledge.
//
// Ports
//   clk          in   rising-edge clock for all logic
//   reset        in   asynchronous, active-low reset
//   bus_reqcyc   in   request valid, or write-beat valid
//   bus_req      in   request address, or write data during write beats
//   bus_reqtag   in   tag: [12] op, [11:8] device, [7:0] transaction id
//   bus_reqack   out  one-cycle accept of a request or of a write beat
//   bus_respcyc  out  read beat valid
//   bus_resp     out  read beat data
//   bus_resptag  out  tag of the request being serviced
//   bus_respack  in   initiator has consumed the current read beat
//
// Configuration macro: SYSBUS_MEMRESP_WRITE_EN
//   defined   : write bursts update the array
//   undefined : write bursts are acked and consumed, but the array is left
//               untouched, so the memory behaves as read-only

`ifndef SYSBUS_READ
`define SYSBUS_READ 1'b1
`endif
`ifndef SYSBUS_WRITE
`define SYSBUS_WRITE 1'b0
`endif
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'b0001
`endif

module sysbus_mem_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_WORDS      = 4096,
  parameter int READ_LATENCY   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      bus_respack
);

  // A word address is {line index, beat}. Only the low line-index bits that
  // fit the array are kept, which gives the silent wrap modulo MEM_WORDS.
  localparam int ADDR_W = $clog2(MEM_WORDS);
  localparam int LINE_W = ADDR_W - 3;
  localparam int LAT_W  = $clog2(READ_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RDATA, WDATA} state_t;

  state_t                    state_q, state_d;
  logic [LINE_W-1:0]         line_q, line_d;
  logic [2:0]                beat_q, beat_d;
  logic [LAT_W-1:0]          lat_q, lat_d;
  logic                      skip_q, skip_d;
  logic                      reqack_q, reqack_d;
  logic                      respcyc_q, respcyc_d;
  logic [BUS_DATA_WIDTH-1:0] resp_q, resp_d;
  logic [BUS_TAG_WIDTH-1:0]  resptag_q, resptag_d;
  logic                      mem_we;

  logic [BUS_DATA_WIDTH-1:0] mem_q [MEM_WORDS];

  // Next-state and next-output logic for the request/response state machine.
  // skip_q marks the cycle in which the address of a write is being acked.
  // An initiator that holds bus_reqcyc until it sees the ack must not have
  // its address taken as the first data beat, so that cycle is ignored.
  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    beat_d    = beat_q;
    lat_d     = lat_q;
    skip_d    = 1'b0;
    reqack_d  = 1'b0;
    respcyc_d = respcyc_q;
    resp_d    = resp_q;
    resptag_d = resptag_q;
    mem_we    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus_reqcyc && (bus_reqtag[11:8] == `SYSBUS_MEMORY)) begin
          line_d    = bus_req[6 +: LINE_W];
          resptag_d = bus_reqtag;
          beat_d    = 3'd0;
          lat_d     = '0;
          reqack_d  = 1'b1;
          if (bus_reqtag[BUS_TAG_WIDTH-1] == `SYSBUS_WRITE) begin
            state_d = WDATA;
            skip_d  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end

      WAIT: begin
        if (lat_q == LAT_W'(READ_LATENCY)) begin
          state_d   = RDATA;
          respcyc_d = 1'b1;
          resp_d    = mem_q[{line_q, 3'd0}];
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end

      RDATA: begin
        if (respcyc_q && bus_respack) begin
          beat_d = beat_q + 3'd1;
          if (beat_q == 3'd7) begin
            respcyc_d = 1'b0;
            state_d   = IDLE;
          end else begin
            resp_d = mem_q[{line_q, beat_q + 3'd1}];
          end
        end
      end

      WDATA: begin
        if (!skip_q && bus_reqcyc) begin
          reqack_d = 1'b1;
          beat_d   = beat_q + 3'd1;
`ifdef SYSBUS_MEMRESP_WRITE_EN
          mem_we   = 1'b1;
`endif
          if (beat_q == 3'd7) begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers. Reset aborts any burst at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      line_q    <= '0;
      beat_q    <= 3'd0;
      lat_q     <= '0;
      skip_q    <= 1'b0;
      reqack_q  <= 1'b0;
      respcyc_q <= 1'b0;
      resp_q    <= '0;
      resptag_q <= '0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      beat_q    <= beat_d;
      lat_q     <= lat_d;
      skip_q    <= skip_d;
      reqack_q  <= reqack_d;
      respcyc_q <= respcyc_d;
      resp_q    <= resp_d;
      resptag_q <= resptag_d;
    end
  end

  // Storage array. It has no reset, so its contents survive a reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[{line_q, beat_q}] <= bus_req;
    end
  end

  assign bus_reqack  = reqack_q;
  assign bus_respcyc = respcyc_q;
  assign bus_resp    = resp_q;
  assign bus_resptag = resptag_q;

endmodule
